sam_con_sched: RTL
==================

SAM_CON_SCHED -- requirements
Module: sam_con_sched

Interface
REQ-001 Parameters (name, default, meaning): KERNEL_SIZE, 8, kernel taps driven to the engine per job; LEN_W, 16, job length counter width.
REQ-002 Clk  input  1  clock, all logic on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 Req  input  2  per-requester job request, level, held until matching Done.
REQ-005 Job_Len0, Job_Len1  input  LEN_W each  total data beats of the job, sampled at grant.
REQ-006 Kernel_Word0, Kernel_Word1  input  2*KERNEL_SIZE each  packed kernel; tap i = bits [2i+1:2i]; sampled at grant.
REQ-007 Data_In0, Data_In1  input  32 each  requester data source.
REQ-008 Data_Rd  output  2  one-hot pop strobe to the granted requester's source.
REQ-009 Grant  output  2  one-hot owner of the engine.
REQ-010 Eng_Rst, Eng_Data[32], Eng_Kernel[2], Eng_Last  output  engine reset, data, serial kernel and last marker.
REQ-011 Eng_Last_Done  input  1  engine's Last_Data_Out.
REQ-012 Done, Err  output  2 each  one-cycle per-requester completion and rejection pulses.

Function
REQ-013 States SHALL be IDLE, ENG_RST, LOAD, STREAM, DRAIN, RELEASE.
- IDLE->ENG_RST on any Req.
- ENG_RST->LOAD after 1 cycle.
- LOAD->STREAM after KERNEL_SIZE beats.
- STREAM->DRAIN on the final beat.
- DRAIN->RELEASE on Eng_Last_Done=1.
- RELEASE->IDLE after 1 cycle.
REQ-014 Arbitration SHALL be round-robin: in IDLE, if both Req are high, grant goes to the requester not served last; the pointer starts at requester 0 after reset and flips in RELEASE.
REQ-015 Grant SHALL assert on the IDLE->ENG_RST edge and deassert in RELEASE; Job_Len and Kernel_Word SHALL be latched on the same edge.
REQ-016 In ENG_RST, Eng_Rst SHALL be 1 for exactly one cycle; Data_Rd SHALL be 0 in that cycle.
REQ-017 Each LOAD and STREAM cycle is one beat:
- Data_Rd[g]=1 and Eng_Data=Data_In[g];
- beat counter increments.
REQ-018 In LOAD beat k (0..KERNEL_SIZE-1), Eng_Kernel SHALL equal latched tap k; outside LOAD, Eng_Kernel SHALL be 0.
REQ-019 Eng_Last SHALL be 1 only on beat Job_Len-1 and SHALL remain 1 through DRAIN.
REQ-020 Job_Len below KERNEL_SIZE+1 SHALL be rejected in ENG_RST:
- Err[g] pulses;
- Done[g] pulses;
- state goes to RELEASE with no beats issued.
REQ-021 Done[g] SHALL pulse for one cycle in RELEASE; Eng_Rst SHALL also be 1 in RELEASE so the engine returns to its initial state.
REQ-022 Req changes after grant SHALL be ignored until RELEASE; a requester dropping Req mid-job does not abort the job.
REQ-023 The beat counter SHALL be LEN_W bits and SHALL never wrap within a job; Job_Len=0 is treated as rejected.

Reset
REQ-024 Rst=1 SHALL force the following regardless of state:
- IDLE, counter 0, pointer 0;
- Grant, Data_Rd, Done, Err, Eng_Last, Eng_Kernel = 0;
- Eng_Data=0, Eng_Rst=1.
REQ-025 Rst asserted mid-job SHALL abandon the job with no Done pulse; the first cycle after Rst releases SHALL be IDLE with Eng_Rst=0.

Configuration
REQ-026 Macro SAM_SCHED_TIMEOUT_EN:
- when defined, a 16-bit DRAIN watchdog SHALL count DRAIN cycles; on reaching 1024 without Eng_Last_Done, it goes to RELEASE with Err[g] and Done[g] pulsing together;
- when undefined, DRAIN waits indefinitely and no watchdog logic exists.

Verification
REQ-027 Single job: Req=01, Job_Len0=20, Kernel_Word0=16'hE4A5, Eng_Last_Done raised 3 cycles after the last beat.
- Grant=01; Eng_Rst for 1 cycle.
- Eng_Kernel sequence 1,1,2,2,0,1,2,3.
- 20 Data_Rd[0] pulses; Eng_Last on beat 19.
- Done[0] pulses once.
REQ-028 Contention: Req=11 held across two jobs from reset -> requester 0 is served first, then requester 1; no Data_Rd overlap.
REQ-029 Rejection: Job_Len1=5, Req=10 -> Err[1] and Done[1] pulse; zero Data_Rd pulses.
REQ-030 Mid-job reset: Rst pulsed in STREAM beat 10 -> all outputs reach reset values next cycle; no Done.
REQ-031 Watchdog (macro defined): Eng_Last_Done held 0 -> Err[0] and Done[0] pulse 1024 cycles after DRAIN entry; with the macro undefined the scheduler stays in DRAIN.

Source files
------------

// File: rtl/sam_con_sched_if.sv
// Scheduler-side bundle: requester job handshake, requester data sources and
// the serial engine port, grouped so the scheduler sees one slave port.
interface sam_con_sched_if #(
   parameter int KERNEL_SIZE = 8,
   parameter int LEN_W       = 16
);
   logic [1:0]               Req;
   logic [LEN_W-1:0]         Job_Len0;
   logic [LEN_W-1:0]         Job_Len1;
   logic [2*KERNEL_SIZE-1:0] Kernel_Word0;
   logic [2*KERNEL_SIZE-1:0] Kernel_Word1;
   logic [31:0]              Data_In0;
   logic [31:0]              Data_In1;
   logic [1:0]               Data_Rd;
   logic [1:0]               Grant;
   logic                     Eng_Rst;
   logic [31:0]              Eng_Data;
   logic [1:0]               Eng_Kernel;
   logic                     Eng_Last;
   logic                     Eng_Last_Done;
   logic [1:0]               Done;
   logic [1:0]               Err;

   modport master (
      output Req, Job_Len0, Job_Len1, Kernel_Word0, Kernel_Word1,
             Data_In0, Data_In1, Eng_Last_Done,
      input  Data_Rd, Grant, Eng_Rst, Eng_Data, Eng_Kernel, Eng_Last,
             Done, Err
   );

   modport slave (
      input  Req, Job_Len0, Job_Len1, Kernel_Word0, Kernel_Word1,
             Data_In0, Data_In1, Eng_Last_Done,
      output Data_Rd, Grant, Eng_Rst, Eng_Data, Eng_Kernel, Eng_Last,
             Done, Err
   );
endinterface

// File: rtl/sam_con_sched.sv
// Two-requester round-robin scheduler feeding a serial-kernel engine.
// Optional DRAIN watchdog enabled by defining SAM_SCHED_TIMEOUT_EN.
module sam_con_sched #(
   parameter int KERNEL_SIZE = 8,
   parameter int LEN_W       = 16
) (
   input  logic           Clk,
   input  logic           Rst,
   sam_con_sched_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      ENG_RST,
      LOAD,
      STREAM,
      DRAIN,
      RELEASE
   } state_t;

   localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(KERNEL_SIZE + 1);
   localparam logic [LEN_W-1:0] LOAD_LAST = LEN_W'(KERNEL_SIZE - 1);

   state_t                   state;
   state_t                   state_n;
   logic                     owner;
   logic                     ptr;
   logic                     pick;
   logic                     err_set;
   logic                     err_q;
   logic [LEN_W-1:0]         cnt;
   logic [LEN_W-1:0]         len_q;
   logic [2*KERNEL_SIZE-1:0] kern_q;
   logic [1:0]               owner_oh;
   logic                     last_beat;

`ifdef SAM_SCHED_TIMEOUT_EN
   logic [15:0]              wd;
`endif

   // With both requesting, the pointer names whoever was not served last.
   assign pick      = (bus.Req == 2'b11) ? ptr : bus.Req[1];
   assign owner_oh  = owner ? 2'b10 : 2'b01;
   assign last_beat = (cnt == len_q - LEN_W'(1));

   always_ff @(posedge Clk) begin
      if (Rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      err_set = 1'b0;
      case (state)
         IDLE:    if (|bus.Req) state_n = ENG_RST;
         ENG_RST: begin
            if (len_q < MIN_LEN) begin
               state_n = RELEASE;
               err_set = 1'b1;
            end else begin
               state_n = LOAD;
            end
         end
         LOAD:    if (cnt == LOAD_LAST) state_n = STREAM;
         STREAM:  if (last_beat) state_n = DRAIN;
         DRAIN: begin
            if (bus.Eng_Last_Done) begin
               state_n = RELEASE;
            end
`ifdef SAM_SCHED_TIMEOUT_EN
            else if (wd == 16'd1023) begin
               state_n = RELEASE;
               err_set = 1'b1;
            end
`endif
         end
         RELEASE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Job parameters are captured once at grant so later Req/input changes cannot disturb the job.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt    <= '0;
         ptr    <= 1'b0;
         owner  <= 1'b0;
         len_q  <= '0;
         kern_q <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= err_set;
         case (state)
            IDLE: begin
               if (|bus.Req) begin
                  owner  <= pick;
                  len_q  <= pick ? bus.Job_Len1 : bus.Job_Len0;
                  kern_q <= pick ? bus.Kernel_Word1 : bus.Kernel_Word0;
               end
            end
            ENG_RST:      cnt <= '0;
            LOAD, STREAM: cnt <= cnt + LEN_W'(1);
            RELEASE:      ptr <= ~owner;
            default:      ;
         endcase
      end
   end

`ifdef SAM_SCHED_TIMEOUT_EN
   always_ff @(posedge Clk) begin
      if (Rst || state != DRAIN)
         wd <= '0;
      else
         wd <= wd + 16'd1;
   end
`endif

   always_comb begin
      bus.Grant      = 2'b00;
      bus.Data_Rd    = 2'b00;
      bus.Done       = 2'b00;
      bus.Err        = 2'b00;
      bus.Eng_Rst    = 1'b0;
      bus.Eng_Data   = 32'd0;
      bus.Eng_Kernel = 2'b00;
      bus.Eng_Last   = 1'b0;
      if (Rst) begin
         bus.Eng_Rst = 1'b1;
      end else begin
         case (state)
            ENG_RST: begin
               bus.Grant   = owner_oh;
               bus.Eng_Rst = 1'b1;
            end
            LOAD: begin
               bus.Grant      = owner_oh;
               bus.Data_Rd    = owner_oh;
               bus.Eng_Data   = owner ? bus.Data_In1 : bus.Data_In0;
               bus.Eng_Kernel = 2'(kern_q >> {cnt, 1'b0});
            end
            STREAM: begin
               bus.Grant    = owner_oh;
               bus.Data_Rd  = owner_oh;
               bus.Eng_Data = owner ? bus.Data_In1 : bus.Data_In0;
               bus.Eng_Last = last_beat;
            end
            DRAIN: begin
               bus.Grant    = owner_oh;
               bus.Eng_Last = 1'b1;
            end
            RELEASE: begin
               bus.Eng_Rst = 1'b1;
               bus.Done    = owner_oh;
               bus.Err     = err_q ? owner_oh : 2'b00;
            end
            default: ;
         endcase
      end
   end

endmodule
